// File: rtl/sad_block_search.sv
// Sub-pel SAD block search: 5 vertical phases x NUM_H horizontal offsets, accumulated over BLK_H rows.
// Define SAD_BEST_EN to build the serial minimum finder (SEARCH state, best_sad/best_idx).
//
// state  | meaning
// ACCUM  | accepting rows, accumulating row SADs
// SEARCH | serial scan for the minimum candidate (SAD_BEST_EN only)
// DONE   | block result presented until out_ready
module sad_block_search #(
  parameter int PIX_W = 8,
  parameter int BLK_W = 4,
  parameter int BLK_H = 4,
  parameter int NUM_H = 5,
  parameter int SAD_W = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [(BLK_W+NUM_H-1)*PIX_W-1:0]    cur_upper,
  input  logic [(BLK_W+NUM_H-1)*PIX_W-1:0]    cur_middle,
  input  logic [(BLK_W+NUM_H-1)*PIX_W-1:0]    cur_lower,
  input  logic [BLK_W*PIX_W-1:0]              org,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [5*NUM_H*SAD_W-1:0]            out_sad,
  output logic [SAD_W-1:0]                    best_sad,
  output logic [$clog2(5*NUM_H)-1:0]          best_idx
);

  localparam int CUR_N = BLK_W + NUM_H - 1;
  localparam int NUM_K = 5 * NUM_H;
  localparam int IDX_W = $clog2(5 * NUM_H);
  localparam int CNT_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  localparam logic [1:0] ACCUM  = 2'd0;
  localparam logic [1:0] DONE   = 2'd1;
`ifdef SAD_BEST_EN
  localparam logic [1:0] SEARCH = 2'd2;
`endif

  logic [1:0]       state;
  logic [CNT_W-1:0] row_cnt;
  logic [SAD_W-1:0] acc     [NUM_K];
  logic [SAD_W-1:0] row_sad [NUM_K];
  logic [PIX_W-1:0] phase   [5][CUR_N];
  logic [PIX_W+1:0] pu, pm, pl;
  logic [PIX_W-1:0] c_pix, o_pix;

  // Vertical interpolation; sums are formed wide enough that U+3M+2 cannot overflow.
  always_comb begin
    phase = '{default: '0};
    pu = '0;
    pm = '0;
    pl = '0;
    for (int j = 0; j < CUR_N; j++) begin
      pu = {2'b00, cur_upper[j*PIX_W +: PIX_W]};
      pm = {2'b00, cur_middle[j*PIX_W +: PIX_W]};
      pl = {2'b00, cur_lower[j*PIX_W +: PIX_W]};
      phase[0][j] = PIX_W'((pu + pm + 1) >> 1);
      phase[1][j] = PIX_W'((pu + 3 * pm + 2) >> 2);
      phase[2][j] = cur_middle[j*PIX_W +: PIX_W];
      phase[3][j] = PIX_W'((pl + 3 * pm + 2) >> 2);
      phase[4][j] = PIX_W'((pl + pm + 1) >> 1);
    end
  end

  always_comb begin
    row_sad = '{default: '0};
    c_pix = '0;
    o_pix = '0;
    for (int m = 0; m < 5; m++) begin
      for (int h = 0; h < NUM_H; h++) begin
        for (int i = 0; i < BLK_W; i++) begin
          c_pix = phase[m][h+i];
          o_pix = org[i*PIX_W +: PIX_W];
          row_sad[m*NUM_H+h] = row_sad[m*NUM_H+h]
                             + SAD_W'((c_pix >= o_pix) ? (c_pix - o_pix) : (o_pix - c_pix));
        end
      end
    end
  end

`ifdef SAD_BEST_EN
  logic [IDX_W-1:0] scan_k;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      row_cnt <= '0;
      for (int k = 0; k < NUM_K; k++) acc[k] <= '0;
`ifdef SAD_BEST_EN
      best_sad <= '0;
      best_idx <= '0;
      scan_k   <= '0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            // First row of a block restarts every accumulator from zero.
            for (int k = 0; k < NUM_K; k++)
              acc[k] <= ((row_cnt == '0) ? '0 : acc[k]) + row_sad[k];
            if (row_cnt == CNT_W'(BLK_H - 1)) begin
              row_cnt <= '0;
`ifdef SAD_BEST_EN
              state  <= SEARCH;
              scan_k <= '0;
`else
              state  <= DONE;
`endif
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
`ifdef SAD_BEST_EN
        SEARCH: begin
          // Strict less-than keeps the lowest index on ties.
          if (scan_k == '0 || acc[scan_k] < best_sad) begin
            best_sad <= acc[scan_k];
            best_idx <= scan_k;
          end
          if (scan_k == IDX_W'(NUM_K - 1)) state <= DONE;
          else scan_k <= scan_k + 1'b1;
        end
`endif
        DONE: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

`ifndef SAD_BEST_EN
  assign best_sad = '0;
  assign best_idx = '0;
`endif

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  always_comb begin
    out_sad = '0;
    for (int k = 0; k < NUM_K; k++) out_sad[k*SAD_W +: SAD_W] = acc[k];
  end

endmodule

// File: tb/tb_sad_block_search.sv
// Directed bench for sad_block_search; expected values are hand-computed per vector.
module tb_sad_block_search;

  localparam int PIX_W = 8, BLK_W = 4, BLK_H = 4, NUM_H = 5, SAD_W = 16;
  localparam int CUR_N = BLK_W + NUM_H - 1;
  localparam int NUM_K = 5 * NUM_H;
  localparam int CW    = CUR_N * PIX_W;
  localparam int OGW   = BLK_W * PIX_W;
  localparam int OW    = NUM_K * SAD_W;
  localparam int IW    = $clog2(NUM_K);
`ifdef SAD_BEST_EN
  localparam int LAT     = 1 + NUM_K;
  localparam bit BEST_ON = 1'b1;
`else
  localparam int LAT     = 1;
  localparam bit BEST_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [CW-1:0]  cur_upper = '0, cur_middle = '0, cur_lower = '0;
  logic [OGW-1:0] org = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [OW-1:0]  out_sad;
  logic [SAD_W-1:0] best_sad;
  logic [IW-1:0]  best_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sad_block_search #(.PIX_W(PIX_W), .BLK_W(BLK_W), .BLK_H(BLK_H), .NUM_H(NUM_H), .SAD_W(SAD_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cur_upper(cur_upper), .cur_middle(cur_middle), .cur_lower(cur_lower), .org(org),
    .out_valid(out_valid), .out_ready(out_ready), .out_sad(out_sad),
    .best_sad(best_sad), .best_idx(best_idx)
  );

  task automatic check_val(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] rep_cur(input logic [7:0] p);
    logic [CW-1:0] r;
    for (int j = 0; j < CUR_N; j++) r[j*PIX_W +: PIX_W] = p;
    return r;
  endfunction

  function automatic logic [OGW-1:0] rep_org(input logic [7:0] p);
    logic [OGW-1:0] r;
    for (int j = 0; j < BLK_W; j++) r[j*PIX_W +: PIX_W] = p;
    return r;
  endfunction

  function automatic logic [OW-1:0] exp_by_m(input int v0, input int v1, input int v2,
                                             input int v3, input int v4);
    logic [OW-1:0] r;
    int v[5];
    v = '{v0, v1, v2, v3, v4};
    for (int m = 0; m < 5; m++)
      for (int h = 0; h < NUM_H; h++) r[(m*NUM_H+h)*SAD_W +: SAD_W] = SAD_W'(v[m]);
    return r;
  endfunction

  task automatic check_fields(input string tag, input logic [OW-1:0] exp);
    for (int k = 0; k < NUM_K; k++)
      check_val($sformatf("%s_k%0d", tag, k), OW'(out_sad[k*SAD_W +: SAD_W]),
                OW'(exp[k*SAD_W +: SAD_W]));
  endtask

  task automatic check_best(input string tag, input int idx, input int sad);
    check_val({tag, "_best_idx"}, OW'(best_idx), BEST_ON ? OW'(idx) : OW'(0));
    check_val({tag, "_best_sad"}, OW'(best_sad), BEST_ON ? OW'(sad) : OW'(0));
  endtask

  task automatic send_row(input logic [CW-1:0] u, input logic [CW-1:0] m,
                          input logic [CW-1:0] l, input logic [OGW-1:0] o);
    int n;
    @(negedge clk);
    cur_upper = u; cur_middle = m; cur_lower = l; org = o;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_val("in_ready_timeout", OW'(in_ready), OW'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [CW-1:0] u, input logic [CW-1:0] m,
                            input logic [CW-1:0] l, input logic [OGW-1:0] o);
    repeat (BLK_H) send_row(u, m, l, o);
  endtask

  // Called right after the last row's accepting edge; latency counts that cycle as 1.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({tag, "_latency"}, OW'(n + 1), OW'(LAT));
  endtask

  task automatic release_done(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_val({tag, "_rel_in_ready"}, OW'(in_ready), OW'(1));
    check_val({tag, "_rel_out_valid"}, OW'(out_valid), OW'(0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_val({tag, "_out_valid"}, OW'(out_valid), OW'(0));
    check_val({tag, "_in_ready"}, OW'(in_ready), OW'(1));
    check_val({tag, "_out_sad"}, out_sad, OW'(0));
    check_best(tag, 0, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0]  lrow;
    logic [OGW-1:0] o4;
    logic [OW-1:0]  e4;
    int m3v[5];
    int m4v[5];

    for (int j = 0; j < CUR_N; j++) lrow[j*PIX_W +: PIX_W] = 8'(4 * (j + 1));
    for (int i = 0; i < BLK_W; i++) o4[i*PIX_W +: PIX_W] = 8'(i + 3);
    m3v = '{32, 16, 0, 16, 32};
    m4v = '{16, 40, 72, 104, 136};
    e4 = exp_by_m(72, 72, 72, 0, 0);
    for (int h = 0; h < NUM_H; h++) begin
      e4[(15+h)*SAD_W +: SAD_W] = SAD_W'(m3v[h]);
      e4[(20+h)*SAD_W +: SAD_W] = SAD_W'(m4v[h]);
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_out_valid", OW'(out_valid), OW'(0));
    check_val("rst_in_ready", OW'(in_ready), OW'(1));
    check_val("rst_out_sad", out_sad, OW'(0));
    check_best("rst", 0, 0);

    // All equal -> every SAD zero, tie resolves to k=0
    send_block(rep_cur(8'h40), rep_cur(8'h40), rep_cur(8'h40), rep_org(8'h40));
    wait_done("t1");
    check_fields("t1", exp_by_m(0, 0, 0, 0, 0));
    check_best("t1", 0, 0);
    release_done("t1");

    // Uniform offset of 16 on every phase -> 4*4*16
    send_block(rep_cur(8'h20), rep_cur(8'h20), rep_cur(8'h20), rep_org(8'h10));
    wait_done("t2");
    check_fields("t2", exp_by_m(256, 256, 256, 256, 256));
    check_best("t2", 0, 256);
    release_done("t2");

    // Rounding: UH=2, UQ=2 match org; M, LQ, LH stay at 3
    send_block(rep_cur(8'h00), rep_cur(8'h03), rep_cur(8'h03), rep_org(8'h02));
    wait_done("t3");
    check_fields("t3", exp_by_m(0, 0, 16, 16, 16));
    check_best("t3", 0, 0);
    release_done("t3");

    // Unique zero at m=3, h=2 (k=17)
    send_block(rep_cur(8'h00), rep_cur(8'h00), lrow, o4);
    wait_done("t4");
    check_fields("t4", e4);
    check_best("t4", 17, 0);

    // Back-pressure in DONE with in_valid asserted
    @(negedge clk);
    cur_upper = rep_cur(8'hFF); cur_middle = rep_cur(8'hFF); cur_lower = rep_cur(8'hFF);
    org = rep_org(8'h00);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_val($sformatf("hold%0d_in_ready", c), OW'(in_ready), OW'(0));
      check_val($sformatf("hold%0d_out_valid", c), OW'(out_valid), OW'(1));
      check_val($sformatf("hold%0d_out_sad", c), out_sad, e4);
    end
    release_done("t5");
    send_block(rep_cur(8'h20), rep_cur(8'h20), rep_cur(8'h20), rep_org(8'h10));
    wait_done("t5b");
    check_fields("t5b", exp_by_m(256, 256, 256, 256, 256));
    check_best("t5b", 0, 256);
    release_done("t5b");

    // Reset mid-block discards the partial sums
    repeat (2) send_row(rep_cur(8'h20), rep_cur(8'h20), rep_cur(8'h20), rep_org(8'h10));
    do_reset("t6_rst");
    send_block(rep_cur(8'hFF), rep_cur(8'hFF), rep_cur(8'hFF), rep_org(8'h00));
    wait_done("t6");
    check_fields("t6", exp_by_m(4080, 4080, 4080, 4080, 4080));
    check_best("t6", 0, 4080);
    release_done("t6");

    // Reset a few cycles after the last row (inside SEARCH when the min-finder is built)
    send_block(rep_cur(8'h00), rep_cur(8'h03), rep_cur(8'h03), rep_org(8'h02));
    repeat (3) @(posedge clk);
    do_reset("t6b_rst");
    send_block(rep_cur(8'h00), rep_cur(8'h00), lrow, o4);
    wait_done("t6b");
    check_fields("t6b", e4);
    check_best("t6b", 17, 0);
    release_done("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
